// File: rtl/program_loader.sv
// program_loader: boot-time loader that receives a byte stream
// (count N, N big-endian instruction words, XOR checksum), writes the words
// to instruction memory from address 0 and holds the CPU in reset until a
// checksum-valid image has been written.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   start            begin a load (honoured in IDLE, DONE, ERROR)
//   in_data/valid    stream byte and its valid flag
//   in_ready         loader accepts a byte this cycle
//   mem_addr/data    instruction memory write address / word
//   mem_en_write     one-cycle write strobe
//   cpu_rst          active-high CPU reset
//   done, error      image verified / checksum mismatch
module program_loader #(
    parameter int unsigned INST_SIZE = 16,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [INST_SIZE-1:0] mem_data,
    output logic                 mem_en_write,
    output logic                 cpu_rst,
    output logic                 done,
    output logic                 error
);

    localparam int unsigned BYTES  = INST_SIZE / 8;
    localparam int unsigned BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [7:0]           n_q, n_d;
    logic [7:0]           xor_q, xor_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [BIDX_W-1:0]    bidx_q, bidx_d;
    logic [INST_SIZE-1:0] asm_q, asm_d;
    logic                 in_ready_q, in_ready_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [INST_SIZE-1:0] mem_data_q, mem_data_d;
    logic                 we_q, we_d;
    logic                 cpu_rst_q, cpu_rst_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic                 accept_c;
    logic [INST_SIZE-1:0] word_c;
    logic                 last_byte_c;
    logic                 last_word_c;

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            xor_q      <= '0;
            addr_q     <= '0;
            bidx_q     <= '0;
            asm_q      <= '0;
            in_ready_q <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            we_q       <= 1'b0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            xor_q      <= xor_d;
            addr_q     <= addr_d;
            bidx_q     <= bidx_d;
            asm_q      <= asm_d;
            in_ready_q <= in_ready_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            we_q       <= we_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        xor_d      = xor_q;
        addr_d     = addr_q;
        bidx_d     = bidx_q;
        asm_d      = asm_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        we_d       = 1'b0;

        accept_c    = in_valid && in_ready_q;
        // Shift the incoming byte in below the bytes already collected (MSB first)
        word_c      = (asm_q << 8) | INST_SIZE'(in_data);
        last_byte_c = (bidx_q == BIDX_W'(BYTES - 1));
        last_word_c = ((addr_q + ADDR_SIZE'(1)) == ADDR_SIZE'(n_q));

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_COUNT;
            end
            S_COUNT: begin
                if (accept_c) begin
                    n_d    = in_data;
                    xor_d  = in_data;
                    addr_d = '0;
                    bidx_d = '0;
                    asm_d  = '0;
                    state_d = (in_data == 8'd0) ? S_CHECK : S_DATA;
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    xor_d = xor_q ^ in_data;
                    asm_d = word_c;
                    if (last_byte_c) begin
                        mem_data_d = word_c;
                        mem_addr_d = addr_q;
                        we_d       = 1'b1;
                        addr_d     = addr_q + ADDR_SIZE'(1);
                        bidx_d     = '0;
                        if (last_word_c) state_d = S_CHECK;
                    end else begin
                        bidx_d = bidx_q + BIDX_W'(1);
                    end
                end
            end
            S_CHECK: begin
                if (accept_c) state_d = (in_data == xor_q) ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (start) state_d = S_COUNT;
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered images of the next state
        in_ready_d = (state_d == S_COUNT) || (state_d == S_DATA) || (state_d == S_CHECK);
        cpu_rst_d  = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERROR);
    end

    assign in_ready     = in_ready_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data     = mem_data_q;
    assign mem_en_write = we_q;
    assign cpu_rst      = cpu_rst_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader (INST_SIZE=16, ADDR_SIZE=8).
module tb_program_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_en_write;
    logic        cpu_rst;
    logic        done;
    logic        error;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  wa_q[$];
    logic [15:0] wd_q[$];

    program_loader #(.INST_SIZE(16), .ADDR_SIZE(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_en_write (mem_en_write),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every cycle the strobe is high; a stretched strobe shows up as an extra write
    always @(negedge clk) begin
        if (mem_en_write === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called just after a posedge; returns just after the posedge that accepts the byte
    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        bit   ok;
        ok       = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_byte_timeout: byte %02h not accepted, got in_ready=%b want 1", b, in_ready);
        end
    endtask

    task automatic send_stream(input bq_t s, input bit gaps, input bit mid_start);
        for (int i = 0; i < s.size(); i++) begin
            if (gaps && i > 0) begin
                int n;
                n        = $urandom_range(1, 3);
                in_valid = 1'b0;
                in_data  = 8'hEE;
                for (int g = 0; g < n; g++) begin
                    if (mid_start && i == 3 && g == 0) start = 1'b1;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
            send_byte(s[i]);
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        if (in_ready !== 1'b0)     begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        if (mem_addr !== 8'h00)    begin failures++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
        if (mem_data !== 16'h0000) begin failures++; $display("FAIL reset_mem_data: got %h want 0000", mem_data); end
        if (mem_en_write !== 1'b0) begin failures++; $display("FAIL reset_mem_en_write: got %b want 0", mem_en_write); end
        if (cpu_rst !== 1'b1)      begin failures++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); end
        if (done !== 1'b0)         begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        if (error !== 1'b0)        begin failures++; $display("FAIL reset_error: got %b want 0", error); end
        checks += 7;
    endtask

    task automatic test_nominal();
        bq_t s;
        s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        wa_q.delete(); wd_q.delete();
        pulse_start();
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL nom_in_ready_after_start: got %b want 1", in_ready); end
        send_stream(s, 1'b0, 1'b0);
        checks += 5;
        if (done !== 1'b1)     begin failures++; $display("FAIL nom_done: got %b want 1", done); end
        if (cpu_rst !== 1'b0)  begin failures++; $display("FAIL nom_cpu_rst: got %b want 0", cpu_rst); end
        if (error !== 1'b0)    begin failures++; $display("FAIL nom_error: got %b want 0", error); end
        if (in_ready !== 1'b0) begin failures++; $display("FAIL nom_in_ready_end: got %b want 0", in_ready); end
        if (wa_q.size() != 2)  begin failures++; $display("FAIL nom_write_count: got %0d want 2", wa_q.size()); end
        else begin
            checks += 2;
            if (wa_q[0] !== 8'h00 || wd_q[0] !== 16'h1234) begin failures++; $display("FAIL nom_write0: got (%h,%h) want (00,1234)", wa_q[0], wd_q[0]); end
            if (wa_q[1] !== 8'h01 || wd_q[1] !== 16'hABCD) begin failures++; $display("FAIL nom_write1: got (%h,%h) want (01,abcd)", wa_q[1], wd_q[1]); end
        end
    endtask

    task automatic test_bad_checksum();
        bq_t s;
        s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        wa_q.delete(); wd_q.delete();
        pulse_start();
        checks += 2;
        if (cpu_rst !== 1'b1) begin failures++; $display("FAIL bad_cpu_rst_after_start: got %b want 1", cpu_rst); end
        if (done !== 1'b0)    begin failures++; $display("FAIL bad_done_after_start: got %b want 0", done); end
        send_stream(s, 1'b0, 1'b0);
        checks += 4;
        if (error !== 1'b1)   begin failures++; $display("FAIL bad_error: got %b want 1", error); end
        if (done !== 1'b0)    begin failures++; $display("FAIL bad_done: got %b want 0", done); end
        if (cpu_rst !== 1'b1) begin failures++; $display("FAIL bad_cpu_rst: got %b want 1", cpu_rst); end
        if (wa_q.size() != 2) begin failures++; $display("FAIL bad_write_count: got %0d want 2", wa_q.size()); end
        else begin
            checks += 2;
            if (wa_q[0] !== 8'h00 || wd_q[0] !== 16'h1234) begin failures++; $display("FAIL bad_write0: got (%h,%h) want (00,1234)", wa_q[0], wd_q[0]); end
            if (wa_q[1] !== 8'h01 || wd_q[1] !== 16'hABCD) begin failures++; $display("FAIL bad_write1: got (%h,%h) want (01,abcd)", wa_q[1], wd_q[1]); end
        end
        pulse_start();
        checks += 2;
        if (error !== 1'b0)    begin failures++; $display("FAIL bad_error_cleared: got %b want 0", error); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bad_in_ready_restart: got %b want 1", in_ready); end
    endtask

    task automatic test_empty();
        bq_t s;
        s = '{8'h00, 8'h00};
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_stream(s, 1'b0, 1'b0);
        @(negedge clk);
        checks += 3;
        if (wa_q.size() != 0) begin failures++; $display("FAIL empty_write_count: got %0d want 0", wa_q.size()); end
        if (done !== 1'b1)    begin failures++; $display("FAIL empty_done: got %b want 1", done); end
        if (cpu_rst !== 1'b0) begin failures++; $display("FAIL empty_cpu_rst: got %b want 0", cpu_rst); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        bq_t s;
        s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_stream(s, 1'b1, 1'b1);
        checks += 4;
        if (done !== 1'b1)    begin failures++; $display("FAIL bp_done: got %b want 1", done); end
        if (cpu_rst !== 1'b0) begin failures++; $display("FAIL bp_cpu_rst: got %b want 0", cpu_rst); end
        if (error !== 1'b0)   begin failures++; $display("FAIL bp_error: got %b want 0", error); end
        if (wa_q.size() != 2) begin failures++; $display("FAIL bp_write_count: got %0d want 2", wa_q.size()); end
        else begin
            checks += 2;
            if (wa_q[0] !== 8'h00 || wd_q[0] !== 16'h1234) begin failures++; $display("FAIL bp_write0: got (%h,%h) want (00,1234)", wa_q[0], wd_q[0]); end
            if (wa_q[1] !== 8'h01 || wd_q[1] !== 16'hABCD) begin failures++; $display("FAIL bp_write1: got (%h,%h) want (01,abcd)", wa_q[1], wd_q[1]); end
        end
    endtask

    task automatic test_async_reset();
        bq_t s;
        s = '{8'h02, 8'h12, 8'h34};
        pulse_start();
        send_stream(s, 1'b0, 1'b0);
        // Third byte just completed word 0, so the strobe and data are live here
        #2;
        rst = 1'b0;
        #1;
        checks += 6;
        if (in_ready !== 1'b0)     begin failures++; $display("FAIL arst_in_ready: got %b want 0", in_ready); end
        if (mem_en_write !== 1'b0) begin failures++; $display("FAIL arst_mem_en_write: got %b want 0", mem_en_write); end
        if (mem_data !== 16'h0000) begin failures++; $display("FAIL arst_mem_data: got %h want 0000", mem_data); end
        if (cpu_rst !== 1'b1)      begin failures++; $display("FAIL arst_cpu_rst: got %b want 1", cpu_rst); end
        if (done !== 1'b0)         begin failures++; $display("FAIL arst_done: got %b want 0", done); end
        if (error !== 1'b0)        begin failures++; $display("FAIL arst_error: got %b want 0", error); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_nominal();
    endtask

    task automatic test_reload();
        bq_t s;
        s = '{8'h01, 8'h00, 8'hFF, 8'hFE};
        wa_q.delete(); wd_q.delete();
        pulse_start();
        checks += 2;
        if (cpu_rst !== 1'b1) begin failures++; $display("FAIL reload_cpu_rst_after_start: got %b want 1", cpu_rst); end
        if (done !== 1'b0)    begin failures++; $display("FAIL reload_done_after_start: got %b want 0", done); end
        send_stream(s, 1'b0, 1'b0);
        checks += 3;
        if (done !== 1'b1)    begin failures++; $display("FAIL reload_done: got %b want 1", done); end
        if (cpu_rst !== 1'b0) begin failures++; $display("FAIL reload_cpu_rst: got %b want 0", cpu_rst); end
        if (wa_q.size() != 1) begin failures++; $display("FAIL reload_write_count: got %0d want 1", wa_q.size()); end
        else begin
            checks++;
            if (wa_q[0] !== 8'h00 || wd_q[0] !== 16'h00FF) begin failures++; $display("FAIL reload_write0: got (%h,%h) want (00,00ff)", wa_q[0], wd_q[0]); end
        end
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_nominal();
        test_bad_checksum();
        test_empty();
        test_backpressure();
        test_async_reset();
        test_reload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader sitting directly upstream of the CPU's instruction memory. It receives a program as a byte stream over a valid/ready handshake and assembles bytes into instruction words. It writes those words sequentially into instruction memory from address 0 and checks a trailing XOR checksum. It holds the CPU in reset until a complete, checksum-valid image has been written.

## Interface

Parameters:
- `INST_SIZE`, 16: instruction word width in bits; must be a multiple of 8.
- `ADDR_SIZE`, 8: instruction memory address width; must be ≥ 8.

Ports:
- `clk`  input  1: single clock; all state changes on posedge.
- `rst`  input  1: asynchronous, active-low reset (0 = reset asserted).
- `start`  input  1: begin a load; sampled only in IDLE, DONE and ERROR.
- `in_data`  input  8: stream byte.
- `in_valid`  input  1: `in_data` is valid.
- `in_ready`  output  1: loader accepts a byte this cycle.
- `mem_addr`  output  ADDR_SIZE: instruction memory write address.
- `mem_data`  output  INST_SIZE: instruction memory write data.
- `mem_en_write`  output  1: one-cycle write strobe.
- `cpu_rst`  output  1: active-high reset to the CPU core.
- `done`  output  1: image loaded and verified.
- `error`  output  1: checksum mismatch on last load.

## Operation

- Byte transfer: a byte is accepted at a posedge where `in_valid && in_ready`. No other cycle consumes a byte.
- Stream format: count byte N (0..255), then N words of `INST_SIZE/8` bytes each (most significant byte first), then one checksum byte.
- Checksum: XOR of the count byte and all data bytes.
- States: IDLE, COUNT, DATA, CHECK, DONE, ERROR.
- IDLE: `start`=1 → COUNT.
- COUNT: on accept, latch N and init running XOR to the byte. N=0 → CHECK; else → DATA with word address 0 and byte index 0.
- DATA, on each accept:
  - shift the byte into the word assembler and XOR it into the checksum.
  - On the last byte of a word: register the assembled word onto `mem_data` and the current word address onto `mem_addr`, pulse `mem_en_write`, then increment the word address.
  - After word N → CHECK.
- CHECK: on accept, compare the byte with the running XOR. Equal → DONE; unequal → ERROR.
- DONE: `done`=1, `cpu_rst`=0. `start`=1 → COUNT, clear `done`, assert `cpu_rst`.
- ERROR: `error`=1, `cpu_rst`=1. `start`=1 → COUNT, clear `error`.
- `start` in COUNT, DATA or CHECK is ignored.
- `in_ready`=1 exactly in COUNT, DATA and CHECK.
- Writes already issued before a checksum failure are not rolled back. The CPU simply stays in reset.
- Address wrap is not possible: N ≤ 255 < 2^ADDR_SIZE.

## Timing

- All outputs are registered.
- Reset values: `in_ready`=0, `mem_addr`=0, `mem_data`=0, `mem_en_write`=0, `cpu_rst`=1, `done`=0, `error`=0; state IDLE.
- Reset asserted mid-load aborts immediately (asynchronously) to the reset values. The partial image is left in memory.
- `start` sampled at edge T → state COUNT and `in_ready`=1 from T+1. `cpu_rst`=1 from T+1 when leaving DONE.
- Last byte of a word accepted at edge T → `mem_en_write`=1 for exactly cycle T..T+1, with `mem_addr`/`mem_data` stable that cycle. Memory captures the word at edge T+1.
- Back-to-back acceptance: one byte per cycle, with no bubbles between words, between the count and data, or between data and checksum.
- Checksum accepted at edge T → `done`/`error` and `cpu_rst` update at T+1 (`cpu_rst` falls at T+1 on success).
- `in_valid` gaps stall the FSM with no state change. Held `in_data` with `in_valid`=0 is never consumed.

## Test plan

- Nominal load: `start`, then bytes 02 12 34 AB CD 42 with `in_valid` held high → writes (0,0x1234) and (1,0xABCD), one strobe each. `done`=1 and `cpu_rst`=0 one cycle after the 0x42 byte is accepted; `in_ready`=0 afterwards.
- Bad checksum: same stream with last byte 0x43 → the same two writes occur, then `error`=1, `cpu_rst` stays 1, `done`=0. A new `start` clears `error`.
- Empty image: bytes 00 00 → no `mem_en_write` pulse, `done`=1, `cpu_rst`=0.
- Backpressure: the nominal stream with `in_valid` low for 1–3 random cycles between bytes → identical writes, addresses and final state. A `start` pulse mid-load is ignored.
- Async reset: drive `rst`=0 between clock edges after 3 bytes accepted → outputs take reset values immediately without waiting for an edge. Release, then the nominal load succeeds.
- Reload from DONE: after a successful load, `start` plus stream 01 00 FF FE → `cpu_rst`=1 the cycle after `start`, write (0,0x00FF), then `done`=1 and `cpu_rst`=0.
